mux_scan_ctrl: RTL
==================

Name: mux_scan_ctrl

Overview:
- Sequencing stage wrapped around the 8-to-1 multiplexer block.
- Drives the mux select lines from a registered counter and samples the returned mux output bit each cycle.
- Assembles the samples into an 8-bit word and hands it downstream over a valid/ready handshake.
- Modes: full scan (all 8 channels) or single-channel capture.

Parameters:
- NCH, 8, number of mux channels; fixed at 8 for this revision.
- SELW, 3, select width; must equal log2(NCH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a capture; sampled only when idle or when completing a handshake.
- mode  input  1  0 = full scan of channels 0..7; 1 = single channel `ch`.
- ch  input  3  channel for single mode; latched at accepted start.
- sel  output  3  registered select to the mux `s` input.
- mux_f  input  1  mux output `f`; combinational from `sel`.
- busy  output  1  high while scanning.
- data  output  8  captured word; stable while `valid` is high.
- valid  output  1  result available.
- ready  input  1  downstream accepts `data` when `valid && ready`.
- scan_cnt  output  8  count of completed handshakes; wraps at 255 to 0.

Behaviour:
- Reset values: sel=0, data=0, valid=0, busy=0, scan_cnt=0, state=IDLE, internal shift word=0.
- States: IDLE, SCAN, HOLD, encoded as a 2-bit registered state.
- IDLE:
  - On start=1, latch mode and ch.
  - Full mode: sel<=0. Single mode: sel<=ch.
  - Clear the internal word, busy<=1, go to SCAN.
- SCAN, full mode:
  - Each cycle, word[sel]<=mux_f.
  - If sel==7: go to HOLD, busy<=0, valid<=1, data<=word with bit 7 = mux_f, and sel holds at 7.
  - Otherwise sel<=sel+1.
  - Exactly 8 SCAN cycles.
- SCAN, single mode:
  - One cycle: data<={7'b0, mux_f}, valid<=1, busy<=0, go to HOLD.
  - sel holds at ch.
- Sampling rule: mux_f is sampled in the same cycle that sel presents that channel. The mux is combinational, so there is no extra wait state.
- Latency (start accepted at edge N): full-mode valid rises at edge N+8; single-mode valid rises at edge N+1.
- HOLD:
  - valid=1; data and sel stay frozen.
  - On valid&&ready: scan_cnt<=scan_cnt+1 (mod 256) and valid<=0.
  - If start=1 in that same cycle, the new capture is accepted exactly as from IDLE and the state goes straight to SCAN (back-to-back). Otherwise the state goes to IDLE.
- start while in SCAN, or in HOLD without ready: ignored, with no queuing.
- Changes on mode or ch after acceptance: no effect until the next accepted start.
- rst mid-SCAN or mid-HOLD: next edge forces all reset values; the partial word is discarded and scan_cnt clears.
- Arithmetic:
  - sel increments are 3-bit and never wrap inside a scan, because the scan terminates at 7.
  - scan_cnt is 8-bit modulo.
- Simultaneous rst with start or ready: rst dominates.

Decomposition:
- Shared package mux_scan_pkg holds:
  - NCH and SELW constants.
  - State encoding: IDLE=2'd0, SCAN=2'd1, HOLD=2'd2; 2'd3 is illegal and recovers to IDLE.
  - MODE_FULL=1'b0 and MODE_SINGLE=1'b1.
- No sub-module inside the block; the controller is one FSM plus a datapath.
- Top-level integration and the bench pair it with the existing 8-to-1 mux: sel drives `s`, and `f` returns as mux_f.

Test Plan:
- Reset then full scan: mux w=8'b1011_0010 (bit index = channel), start=1 for 1 cycle, ready=1 -> sel steps 0..7 on successive cycles; valid rises 8 cycles after start is accepted; data=8'b1011_0010; scan_cnt=1.
- Single mode: mode=1, ch=5, w[5]=1, start -> valid one cycle later; data=8'h01; sel=5 throughout HOLD. Repeat with w[5]=0 -> data=8'h00.
- Backpressure: full scan with ready=0 for 10 cycles after valid -> data, valid and sel frozen; start pulses are ignored. Then ready=1 -> single handshake; scan_cnt increments by exactly 1.
- Back-to-back: start and ready both high in the HOLD cycle -> next state SCAN with no IDLE cycle; second word correct after w is changed to 8'h5A.
- Reset mid-scan: assert rst when sel=3 -> next edge gives sel=0, busy=0, valid=0, data=0, scan_cnt=0; a subsequent scan works normally.
- Wrap: 256 completed handshakes -> scan_cnt returns to 0; start during SCAN never shortens or restarts a scan.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared constants for the mux scan controller.
// State encoding, mode values and channel geometry.
package mux_scan_pkg;

  localparam int NCH  = 8;
  localparam int SELW = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic MODE_FULL   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/mux_scan_ctrl.sv
// Sequencer around the 8-to-1 mux: steps sel, samples f,
// and hands the assembled word downstream on valid/ready.
module mux_scan_ctrl
  import mux_scan_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  input  logic [SELW-1:0] ch,
  output logic [SELW-1:0] sel,
  input  logic            mux_f,
  output logic            busy,
  output logic [NCH-1:0]  data,
  output logic            valid,
  input  logic            ready,
  output logic [7:0]      scan_cnt
);

  logic [1:0]     state;
  logic           mode_q;
  logic [NCH-1:0] word;
  logic           take;
  logic           last;

  assign take = start &&
                (state == IDLE ||
                 (state == HOLD && ready));
  assign last = (sel == SELW'(NCH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= MODE_FULL;
      sel      <= '0;
      word     <= '0;
      data     <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      scan_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: ;
        SCAN: begin
          if (mode_q == MODE_SINGLE) begin
            data  <= {{(NCH-1){1'b0}}, mux_f};
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= HOLD;
          end else begin
            word[sel] <= mux_f;
            if (last) begin
              data  <= {mux_f, word[NCH-2:0]};
              valid <= 1'b1;
              busy  <= 1'b0;
              state <= HOLD;
            end else begin
              sel <= sel + SELW'(1);
            end
          end
        end
        HOLD: begin
          if (ready) begin
            scan_cnt <= scan_cnt + 8'd1;
            valid    <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Accepting a start overrides the HOLD->IDLE step,
      // giving back-to-back captures with no idle cycle.
      if (take) begin
        mode_q <= mode;
        sel    <= (mode == MODE_SINGLE) ? ch : '0;
        word   <= '0;
        busy   <= 1'b1;
        state  <= SCAN;
      end
    end
  end

endmodule
